// File: rtl/pack_serializer.sv
// pack_serializer: accepts one wide packet word, decodes its header and streams the payload lanes as beats.
//   clk       - sole clock
//   rst_n     - synchronous active-low reset
//   in_valid  - packet word offered; in_ready high only while idle; in_pack is the packet word
//   out_*     - payload beat stream (valid/ready handshake, sop on first beat, eop on last beat)
//   prior_o, addr_o, len_o - header fields of the last valid packet, presented from its header cycle
//   wr_ena, rd_ena - one-cycle command pulse in the header cycle (rd when length <= RD_MAX_LEN)
//   err_len   - one-cycle pulse when the header length is zero or does not fit in the word
//   pkt_cnt   - count of fully delivered packets, wrapping at 16 bits
module pack_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int PACK_LANES   = 128,
    parameter int PRIORITY_BIT = 3,
    parameter int ADDR_BIT     = 14,
    parameter int RD_MAX_LEN   = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [PACK_LANES*DATA_WIDTH-1:0] in_pack,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_sop,
    output logic                             out_eop,
    output logic [PRIORITY_BIT-1:0]          prior_o,
    output logic [ADDR_BIT-1:0]              addr_o,
    output logic [7:0]                       len_o,
    output logic                             wr_ena,
    output logic                             rd_ena,
    output logic                             err_len,
    output logic [15:0]                      pkt_cnt
);
    localparam int IW = $clog2(PACK_LANES);

    typedef enum logic [1:0] {IDLE, HDR, STREAM} state_t;

    state_t                           state, state_nx;
    logic [PACK_LANES*DATA_WIDTH-1:0] pack_q;
    logic [DATA_WIDTH-1:0]            lanes [PACK_LANES];
    logic [IW-1:0]                    idx;
    logic [IW-1:0]                    lane_sel;
    logic [PRIORITY_BIT-1:0]          prior_q;
    logic [ADDR_BIT-1:0]              addr_q;
    logic [7:0]                       len_q;
    logic [7:0]                       hdr_len;
    logic [PRIORITY_BIT-1:0]          hdr_prior;
    logic [ADDR_BIT-1:0]              hdr_addr;
    logic                             len_bad;
    logic                             cmd;
    logic                             last;
    logic                             accept;
    logic                             fire;

    // lane 0 is the most significant lane of the word
    for (genvar k = 0; k < PACK_LANES; k++) begin : g_lane
        assign lanes[k] = pack_q[(PACK_LANES-k)*DATA_WIDTH-1 -: DATA_WIDTH];
    end

    assign hdr_len   = 8'(lanes[0]);
    assign hdr_prior = PRIORITY_BIT'(lanes[1]);
    assign hdr_addr  = ADDR_BIT'({lanes[2], lanes[3]});
    assign len_bad   = (hdr_len == 8'd0) || (int'(hdr_len) > PACK_LANES - 4);
    assign cmd       = (state == HDR) && !len_bad;

    // idx never exceeds L-1 <= PACK_LANES-5, so the payload lane index stays in range
    assign lane_sel  = idx + IW'(4);
    assign last      = int'(idx) == int'(hdr_len) - 1;

    // gating with rst_n keeps the word refused for as long as reset is held
    assign in_ready  = rst_n && (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = state == STREAM;
    assign fire      = out_valid && out_ready;
    assign out_data  = out_valid ? lanes[lane_sel] : '0;
    assign out_sop   = out_valid && (idx == '0);
    assign out_eop   = out_valid && last;
    assign err_len   = (state == HDR) && len_bad;
    assign rd_ena    = cmd && (int'(hdr_len) <= RD_MAX_LEN);
    assign wr_ena    = cmd && (int'(hdr_len) > RD_MAX_LEN);

    // new header fields show up alongside the command pulse, then hold from the registers
    assign prior_o   = cmd ? hdr_prior : prior_q;
    assign addr_o    = cmd ? hdr_addr : addr_q;
    assign len_o     = cmd ? hdr_len : len_q;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? HDR : IDLE;
            HDR:     state_nx = len_bad ? IDLE : STREAM;
            STREAM:  state_nx = (fire && last) ? IDLE : STREAM;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            prior_q <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            pkt_cnt <= '0;
        end else begin
            state <= state_nx;
            if (cmd) begin
                prior_q <= hdr_prior;
                addr_q  <= hdr_addr;
                len_q   <= hdr_len;
                idx     <= '0;
            end
            if (fire) begin
                idx <= last ? '0 : idx + 1'b1;
                if (last)
                    pkt_cnt <= pkt_cnt + 1'b1;
            end
        end
    end

    // the word only needs holding while a packet is in flight, so it carries no reset
    always_ff @(posedge clk) begin
        if (accept)
            pack_q <= in_pack;
    end

endmodule

// File: doc/pack_serializer.md
PACK_SERIALIZER -- requirements
Module: pack_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning lane/beat width in bits.
REQ-002 SHALL have parameter PACK_LANES, default 128, meaning lanes per packet word (packet = PACK_LANES*DATA_WIDTH bits).
REQ-003 SHALL have parameter PRIORITY_BIT, default 3, meaning priority field width.
REQ-004 SHALL have parameter ADDR_BIT, default 14, meaning address width (ADDR_BIT <= 2*DATA_WIDTH).
REQ-005 SHALL have parameter RD_MAX_LEN, default 4, meaning the largest payload length classed as read request.
REQ-006 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports: in_valid  in  1  packet offered; in_ready  out  1  packet accepted when both high; in_pack  in  PACK_LANES*DATA_WIDTH  packet word.
REQ-008 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  DATA_WIDTH; out_sop  out  1; out_eop  out  1.
REQ-009 SHALL have ports: prior_o  out  PRIORITY_BIT; addr_o  out  ADDR_BIT; len_o  out  8; wr_ena  out  1; rd_ena  out  1; err_len  out  1; pkt_cnt  out  16.

Function
REQ-010 Lane k SHALL be in_pack[(PACK_LANES-k)*DATA_WIDTH-1 -: DATA_WIDTH]; lane 0 is most significant.
REQ-011 Header SHALL be: lane0 low 8 bits = payload length L; lane1 low PRIORITY_BIT bits = priority; {lane2,lane3} low ADDR_BIT bits = address; payload SHALL be lanes 4..4+L-1.
REQ-012 FSM SHALL have states IDLE, HDR, STREAM; in_ready SHALL be 1 only in IDLE.
REQ-013 IDLE: on in_valid&&in_ready the word SHALL be registered and the FSM SHALL go to HDR; otherwise it SHALL stay in IDLE.
REQ-014 HDR (exactly one cycle): if L==0 or L>PACK_LANES-4, err_len SHALL pulse 1 cycle, no beats or command SHALL be issued, and the FSM SHALL return to IDLE.
REQ-015 HDR with valid L: prior_o, addr_o, len_o SHALL be latched and held until the next valid header; rd_ena SHALL pulse 1 cycle if L<=RD_MAX_LEN, else wr_ena SHALL pulse 1 cycle; the FSM SHALL go to STREAM.
REQ-016 STREAM: out_valid SHALL be 1; out_data SHALL be lane 4+idx, with idx starting at 0.
REQ-017 out_sop SHALL be 1 iff idx==0; out_eop SHALL be 1 iff idx==L-1 (both 1 when L==1); both SHALL be 0 outside STREAM.
REQ-018 idx SHALL advance only on out_valid&&out_ready; while out_ready==0, out_data, out_sop and out_eop SHALL be held stable.
REQ-019 On the handshake with out_eop==1, pkt_cnt SHALL increment (wrapping 0xFFFF->0), and the FSM SHALL go to IDLE with out_valid 0 in the next cycle.
REQ-020 Latency SHALL be: accept at cycle T, command pulse at T+1, first beat valid at T+2; minimum packet period SHALL be L+2 cycles.
REQ-021 Errored packets SHALL NOT increment pkt_cnt.
REQ-022 idx SHALL be wide enough for PACK_LANES-1 and SHALL never index beyond lane 4+L-1.

Reset
REQ-023 While rst_n==0 at a clk edge: the FSM SHALL go to IDLE; in_ready, out_valid, out_data, out_sop, out_eop, prior_o, addr_o, len_o, wr_ena, rd_ena, err_len, pkt_cnt and idx SHALL be 0.
REQ-024 in_ready SHALL be 0 during reset and 1 in the first cycle after rst_n rises.
REQ-025 A reset in HDR or STREAM SHALL abort the packet immediately: no further beats, no eop, no pkt_cnt increment.

Verification
REQ-026 L=1, prio=5, addr=0x1ABC, lane4=0x5A, out_ready=1 -> rd_ena pulse at T+1, prior_o=5, addr_o=0x1ABC; single beat 0x5A at T+2 with sop=eop=1; pkt_cnt=1.
REQ-027 L=6, lanes4..9=0x01..0x06, out_ready=1 -> wr_ena pulse; beats 0x01..0x06 on consecutive cycles, sop on 0x01, eop on 0x06; in_ready high again at T+8.
REQ-028 L=4 with out_ready toggling 1,0,0,1,... -> rd_ena (boundary L==RD_MAX_LEN); beats held stable during stalls; exactly 4 handshakes, no duplicates.
REQ-029 L=0, then L=125 -> err_len pulse for each; no out_valid, no wr/rd pulse, pkt_cnt unchanged; L=124 -> accepted, 124 beats.
REQ-030 Reset asserted on the 3rd beat of L=8 -> next cycle out_valid=0 and all outputs 0; the following packet streams correctly from sop.
REQ-031 0x10000 back-to-back valid packets -> pkt_cnt wraps to 0.
